// File: rtl/sd_pkg.sv
// Shared constants, R1 status helper and FSM state encoding for the SPI-mode SD card responder.
package sd_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC     = 3;

    localparam int FRAME_LEN = 48;
    localparam int R1_LEN    = 8;
    localparam int R7_LEN    = 40;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_RX,
        ST_NCR,
        ST_TX
    } sd_state_t;

    function automatic logic [7:0] r1_make(input logic illegal, input logic crc, input logic idle);
        logic [7:0] r;
        r             = '0;
        r[R1_IDLE]    = idle;
        r[R1_ILLEGAL] = illegal;
        r[R1_CRC]     = crc;
        return r;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per clock, MSB first.
// Asserting clear together with en restarts the CRC from zero with the current bit.
module sd_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] base;
    logic       fb;

    always_comb begin
        base = clear ? 7'h00 : crc;
        fb   = bit_in ^ base[6];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (en) begin
            crc <= {base[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end else if (clear) begin
            crc <= '0;
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes 48-bit command frames and answers with R1/R7.
// Optional CRC7 checking of incoming frames is enabled by defining SD_CRC7_CHECK_EN.
module sd_spi_responder
    import sd_pkg::*;
#(
    parameter int PWRUP_CLKS = 74,
    parameter int NCR_CYC    = 8,
    parameter int BUSY_CNT   = 2
) (
    input  logic        SD_CK,
    input  logic        rst,
    input  logic        SD_CSn,
    input  logic        SD_MOSI,
    output logic        SD_MISO,
    output logic        cmd_valid,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    output logic        card_idle,
    output logic        init_done,
    output logic        crc_err
);

    localparam logic [7:0] PWR_LAST = 8'(PWRUP_CLKS - 1);
    localparam logic [7:0] NCR_LAST = 8'(NCR_CYC - 1);
    localparam logic [7:0] BUSY_LIM = 8'(BUSY_CNT);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_LEN - 1);
    localparam logic [5:0] CRC_END  = 6'(FRAME_LEN - 8);

    sd_state_t   state;
    logic [45:0] rx_sh;
    logic [5:0]  bit_cnt;
    logic [7:0]  ncr_cnt;
    logic [39:0] tx_sh;
    logic [5:0]  tx_left;
    logic [7:0]  pwr_cnt;
    logic [7:0]  busy;
    logic        powered;
    logic        seen_cmd0;
    logic        app;

    logic [46:0] frame;
    logic [5:0]  f_idx;
    logic [31:0] f_arg;
    logic        frame_ok;
    logic        start_seen;
    logic        respond;
    logic        crc_ok;

    // Frame as it stands on the cycle its end bit arrives (start bit implied 0).
    assign frame      = {rx_sh, SD_MOSI};
    assign f_idx      = frame[45:40];
    assign f_arg      = frame[39:8];
    assign frame_ok   = frame[46] & frame[0];
    assign start_seen = ~SD_CSn & ~SD_MOSI;
    assign respond    = frame_ok & powered & (seen_cmd0 | (f_idx == CMD0));
    assign init_done  = powered & ~card_idle;

`ifdef SD_CRC7_CHECK_EN
    logic       crc_clear;
    logic       crc_en;
    logic [6:0] crc_val;

    assign crc_clear = (state == ST_HUNT);
    assign crc_en    = ((state == ST_HUNT) & start_seen) |
                       ((state == ST_RX) & ~SD_CSn & (bit_cnt < CRC_END));

    sd_crc7 u_crc7 (
        .clk    (SD_CK),
        .rst    (rst),
        .clear  (crc_clear),
        .en     (crc_en),
        .bit_in (SD_MOSI),
        .crc    (crc_val)
    );

    assign crc_ok = (crc_val == frame[7:1]);
`else
    logic unused_crc_field;
    assign unused_crc_field = ^{frame[7:1], CRC_END};
    assign crc_ok           = 1'b1;
`endif

    logic        next_idle;
    logic [7:0]  next_busy;
    logic        next_app;
    logic        resp_long;
    logic [7:0]  r1;
    logic [31:0] r7_tail;
    logic [39:0] resp_data;
    logic [5:0]  resp_len_m1;

    // Command decode: state updates and the response word (R1 in the top byte).
    always_comb begin
        next_idle = card_idle;
        next_busy = busy;
        next_app  = 1'b0;
        resp_long = 1'b0;
        r1        = r1_make(1'b1, 1'b0, card_idle);
        r7_tail   = '0;
        if (!crc_ok) begin
            r1 = r1_make(1'b0, 1'b1, card_idle);
        end else begin
            case (f_idx)
                CMD0: begin
                    next_idle = 1'b1;
                    next_busy = '0;
                    r1        = 8'h01;
                end
                CMD8: begin
                    r1        = r1_make(1'b0, 1'b0, card_idle);
                    resp_long = 1'b1;
                    r7_tail   = {4'h0, 16'h0000, (f_arg[11:8] == 4'h1) ? 4'h1 : 4'h0, f_arg[7:0]};
                end
                CMD55: begin
                    r1       = r1_make(1'b0, 1'b0, card_idle);
                    next_app = 1'b1;
                end
                CMD41: begin
                    if (app) begin
                        if (busy < BUSY_LIM) begin
                            next_busy = busy + 8'd1;
                            r1        = 8'h01;
                        end else begin
                            next_idle = 1'b0;
                            r1        = 8'h00;
                        end
                    end
                end
                default: ;
            endcase
        end
        resp_data   = {r1, r7_tail};
        resp_len_m1 = resp_long ? 6'(R7_LEN - 1) : 6'(R1_LEN - 1);
    end

    // Power-up detection plus the receive / NCR / transmit state machine.
    always_ff @(posedge SD_CK or posedge rst) begin
        if (rst) begin
            state     <= ST_HUNT;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            ncr_cnt   <= '0;
            tx_sh     <= '0;
            tx_left   <= '0;
            pwr_cnt   <= '0;
            busy      <= '0;
            powered   <= 1'b0;
            seen_cmd0 <= 1'b0;
            app       <= 1'b0;
            SD_MISO   <= 1'b1;
            cmd_valid <= 1'b0;
            cmd_idx   <= '0;
            cmd_arg   <= '0;
            card_idle <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            crc_err   <= 1'b0;

            if (SD_CSn & SD_MOSI) begin
                if (pwr_cnt != 8'hFF) pwr_cnt <= pwr_cnt + 8'd1;
                if (pwr_cnt >= PWR_LAST) powered <= 1'b1;
            end else begin
                pwr_cnt <= '0;
            end

            case (state)
                ST_HUNT: begin
                    if (start_seen) begin
                        state   <= ST_RX;
                        bit_cnt <= 6'd1;
                        rx_sh   <= '0;
                    end
                end
                ST_RX: begin
                    if (SD_CSn) begin
                        state <= ST_HUNT;
                    end else if (bit_cnt == LAST_BIT) begin
                        if (respond) begin
                            if (crc_ok) begin
                                cmd_valid <= 1'b1;
                                cmd_idx   <= f_idx;
                                cmd_arg   <= f_arg;
                                card_idle <= next_idle;
                                busy      <= next_busy;
                                app       <= next_app;
                                if (f_idx == CMD0) seen_cmd0 <= 1'b1;
                            end else begin
                                crc_err <= 1'b1;
                            end
                            tx_sh   <= resp_data;
                            tx_left <= resp_len_m1;
                            ncr_cnt <= '0;
                            state   <= ST_NCR;
                        end else begin
                            state <= ST_HUNT;
                        end
                    end else begin
                        rx_sh   <= {rx_sh[44:0], SD_MOSI};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                // CSn/MOSI are deliberately ignored here: the host may deselect while awaiting R7.
                ST_NCR: begin
                    if (ncr_cnt == NCR_LAST) begin
                        SD_MISO <= tx_sh[39];
                        tx_sh   <= {tx_sh[38:0], 1'b0};
                        state   <= ST_TX;
                    end else begin
                        ncr_cnt <= ncr_cnt + 8'd1;
                    end
                end
                ST_TX: begin
                    if (tx_left == 6'd0) begin
                        SD_MISO <= 1'b1;
                        state   <= ST_HUNT;
                    end else begin
                        SD_MISO <= tx_sh[39];
                        tx_sh   <= {tx_sh[38:0], 1'b0};
                        tx_left <= tx_left - 6'd1;
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: directed init sequence plus randomized commands
// checked against a behavioural card model.
module tb_sd_spi_responder;

    localparam int PWRUP = 74;
    localparam int NCR   = 8;
    localparam int BUSY  = 2;

    logic        SD_CK   = 1'b0;
    logic        rst     = 1'b1;
    logic        SD_CSn  = 1'b1;
    logic        SD_MOSI = 1'b1;
    logic        SD_MISO;
    logic        cmd_valid;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        card_idle;
    logic        init_done;
    logic        crc_err;

    int checks      = 0;
    int errors      = 0;
    int valid_seen  = 0;
    int crcerr_seen = 0;

    bit          m_powered;
    bit          m_seen0;
    bit          m_idle;
    bit          m_app;
    int          m_busy;
    logic [5:0]  m_idx;
    logic [31:0] m_arg;

    sd_spi_responder #(
        .PWRUP_CLKS (PWRUP),
        .NCR_CYC    (NCR),
        .BUSY_CNT   (BUSY)
    ) dut (
        .SD_CK     (SD_CK),
        .rst       (rst),
        .SD_CSn    (SD_CSn),
        .SD_MOSI   (SD_MOSI),
        .SD_MISO   (SD_MISO),
        .cmd_valid (cmd_valid),
        .cmd_idx   (cmd_idx),
        .cmd_arg   (cmd_arg),
        .card_idle (card_idle),
        .init_done (init_done),
        .crc_err   (crc_err)
    );

    always #5 SD_CK = ~SD_CK;

    always @(negedge SD_CK) begin
        if (cmd_valid === 1'b1) valid_seen++;
        if (crc_err === 1'b1) crcerr_seen++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mkFrame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7(head), 1'b1};
    endfunction

    // Card model: answers from the command rules, right-aligned response value.
    task automatic modelCommand(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok,
                                input bit frame_ok, output bit resp, output int len,
                                output logic [39:0] val, output bit acc);
        resp = 0;
        acc  = 0;
        len  = 8;
        val  = '0;
        if (frame_ok && m_powered && (m_seen0 || idx == 6'd0)) begin
            resp = 1;
            if (!crc_ok) begin
                val = 40'(8'h08 + 8'(m_idle));
            end else begin
                acc   = 1;
                m_idx = idx;
                m_arg = arg;
                if (idx == 6'd0) begin
                    m_idle  = 1;
                    m_busy  = 0;
                    m_seen0 = 1;
                    m_app   = 0;
                    val     = 40'h01;
                end else if (idx == 6'd8) begin
                    len   = 40;
                    val   = {7'b0, m_idle, 20'h0, (arg[11:8] == 4'h1) ? 4'h1 : 4'h0, arg[7:0]};
                    m_app = 0;
                end else if (idx == 6'd55) begin
                    val   = 40'(m_idle);
                    m_app = 1;
                end else if (idx == 6'd41 && m_app) begin
                    if (m_busy < BUSY) begin
                        m_busy++;
                        val = 40'h01;
                    end else begin
                        m_idle = 0;
                        val    = 40'h00;
                    end
                    m_app = 0;
                end else begin
                    val   = 40'(8'h04 + 8'(m_idle));
                    m_app = 0;
                end
            end
        end
    endtask

    task automatic doReset();
        rst     = 1'b1;
        SD_CSn  = 1'b1;
        SD_MOSI = 1'b1;
        repeat (3) @(negedge SD_CK);
        checkOutput("rst_miso", SD_MISO, 1);
        checkOutput("rst_valid", cmd_valid, 0);
        checkOutput("rst_idx", cmd_idx, 0);
        checkOutput("rst_arg", cmd_arg, 0);
        checkOutput("rst_idle", card_idle, 0);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_crc_err", crc_err, 0);
        rst       = 1'b0;
        m_powered = 0;
        m_seen0   = 0;
        m_idle    = 0;
        m_app     = 0;
        m_busy    = 0;
        m_idx     = '0;
        m_arg     = '0;
    endtask

    task automatic powerUp(input int n);
        repeat (n) begin
            @(negedge SD_CK);
            SD_CSn  = 1'b1;
            SD_MOSI = 1'b1;
        end
        if (n >= PWRUP) m_powered = 1;
    endtask

    task automatic sendFrame(input logic [47:0] f, input bit raise_cs);
        for (int i = 47; i >= 0; i--) begin
            @(negedge SD_CK);
            SD_CSn  = 1'b0;
            SD_MOSI = f[i];
        end
        @(negedge SD_CK);
        SD_MOSI = 1'b1;
        SD_CSn  = raise_cs;
    endtask

    task automatic readResponse(input string tag, input int len, output logic [39:0] val,
                                output int highs, output bit got);
        highs = 0;
        val   = '0;
        while (SD_MISO === 1'b1 && highs < NCR + 20) begin
            highs++;
            @(negedge SD_CK);
        end
        got = (SD_MISO === 1'b0);
        if (!got) begin
            checkOutput({tag, "_start"}, 0, 1);
        end else begin
            val = 40'(SD_MISO);
            for (int i = 1; i < len; i++) begin
                @(negedge SD_CK);
                val = {val[38:0], SD_MISO};
            end
            @(negedge SD_CK);
            checkOutput({tag, "_tail"}, SD_MISO, 1);
        end
    endtask

    task automatic expectSilence(input int n, input string tag);
        int high;
        high = 0;
        repeat (n) begin
            @(negedge SD_CK);
            SD_CSn  = 1'b1;
            SD_MOSI = 1'b0;
            if (SD_MISO === 1'b1) high++;
        end
        checkOutput(tag, high, n);
    endtask

    task automatic applyStimulus(input string tag, input logic [47:0] f, input bit raise_cs);
        bit          crc_ok;
        bit          fok;
        bit          resp;
        bit          acc;
        bit          got;
        int          len;
        int          highs;
        int          v0;
        int          c0;
        logic [39:0] exp_val;
        logic [39:0] got_val;
`ifdef SD_CRC7_CHECK_EN
        crc_ok = (f[7:1] === crc7(f[47:8]));
`else
        crc_ok = 1;
`endif
        fok = !f[47] && f[46] && f[0];
        v0  = valid_seen;
        c0  = crcerr_seen;
        modelCommand(f[45:40], f[39:8], crc_ok, fok, resp, len, exp_val, acc);
        sendFrame(f, raise_cs);
        if (resp) begin
            readResponse(tag, len, got_val, highs, got);
            if (got) begin
                checkOutput({tag, "_ncr"}, highs, NCR);
                checkOutput({tag, "_resp"}, got_val, exp_val);
            end
        end else begin
            expectSilence(60, {tag, "_silent"});
        end
        checkOutput({tag, "_valid"}, valid_seen - v0, acc);
        checkOutput({tag, "_crcerr"}, crcerr_seen - c0, resp && !crc_ok);
        if (acc) begin
            checkOutput({tag, "_idx"}, cmd_idx, m_idx);
            checkOutput({tag, "_arg"}, cmd_arg, m_arg);
        end
        checkOutput({tag, "_idle"}, card_idle, m_idle);
        checkOutput({tag, "_init_done"}, init_done, m_powered && !m_idle);
    endtask

    initial begin
        logic [47:0] f;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          v0;

        $display("[TB] start");

        // Basic power-up and CMD0.
        doReset();
        powerUp(80);
        applyStimulus("t1_cmd0", 48'h400000000095, 0);

        // Insufficient power-up, exact boundary below and at the threshold.
        doReset();
        powerUp(20);
        applyStimulus("t2_early", 48'h400000000095, 0);
        powerUp(73);
        applyStimulus("t2_73clk", 48'h400000000095, 0);
        powerUp(74);
        applyStimulus("t2_74clk", 48'h400000000095, 0);

        // CMD8 with CSn raised during the response, then a non-matching voltage field.
        applyStimulus("t3_cmd8_1aa", 48'h48000001AA87, 1);
        applyStimulus("t3_cmd8_2aa", mkFrame(6'd8, 32'h000002AA), 0);

        // ACMD41 busy handshake.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t4_cmd55", 48'h770000000065, 0);
            applyStimulus("t4_acmd41", 48'h694000000077, 0);
        end
        applyStimulus("t4_cmd55_ready", 48'h770000000065, 0);

        // Illegal commands after init, then back to idle.
        applyStimulus("t5_cmd17", 48'h510000000055, 0);
        applyStimulus("t5_cmd41_noapp", mkFrame(6'd41, 32'h40000000), 0);
        applyStimulus("t5_cmd0", 48'h400000000095, 0);

        // Frame aborted by CSn at bit 20.
        v0 = valid_seen;
        f  = 48'h400000000095;
        for (int i = 47; i >= 28; i--) begin
            @(negedge SD_CK);
            SD_CSn  = 1'b0;
            SD_MOSI = f[i];
        end
        expectSilence(80, "t6_partial_silent");
        checkOutput("t6_partial_valid", valid_seen - v0, 0);
        applyStimulus("t6_cmd0", 48'h400000000095, 0);

        // Bad end bit is dropped; bad CRC field is flagged only when checking is built in.
        applyStimulus("t6_endbit", 48'h400000000094, 0);
        applyStimulus("t6_badcrc", 48'h400000000001, 0);

        // Randomized command mix.
        for (int i = 0; i < 40; i++) begin
            arg = $urandom;
            case ($urandom_range(0, 6))
                0:       idx = 6'd0;
                1:       idx = 6'd8;
                2, 3:    idx = 6'd55;
                4:       idx = 6'd41;
                5:       idx = 6'd17;
                default: idx = 6'($urandom_range(0, 63));
            endcase
            if (idx == 6'd8) arg[11:8] = 4'($urandom_range(0, 2));
            f = mkFrame(idx, arg);
            if ($urandom_range(0, 7) == 0) f[7:1] = f[7:1] ^ 7'h11;
            applyStimulus("rand", f, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a response.
        sendFrame(48'h400000000095, 0);
        repeat (NCR + 2) @(negedge SD_CK);
        checkOutput("midtx_bit", SD_MISO, 0);
        #1 rst = 1'b1;
        #1 checkOutput("midtx_rst_miso", SD_MISO, 1);
        doReset();
        applyStimulus("post_rst_nopwr", 48'h400000000095, 0);
        powerUp(74);
        applyStimulus("post_rst_cmd0", 48'h400000000095, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
